// File: rtl/avgvar_sched.sv
// avgvar_sched: round-robin scheduler sharing one AvgVar datapath between
// NCH sample streams. The datapath input is locked to one channel for a whole
// block of BLK samples. Each result is tagged with its channel through an
// in-order tag FIFO of depth TAGD.
// Optional build macro AVGVAR_SCHED_PRIO0_EN: channel 0 gets strict priority
// in arbitration; channels 1..NCH-1 round-robin among themselves.
module avgvar_sched #(
  parameter int NCH  = 4,
  parameter int BLK  = 8,
  parameter int TAGD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_vld,
  output logic [NCH-1:0]          ch_rdy,
  input  logic [8*NCH-1:0]        ch_data,
  output logic                    dp_idata_vld,
  input  logic                    dp_idata_rdy,
  output logic [7:0]              dp_idata,
  input  logic                    dp_odata_vld,
  output logic                    dp_odata_rdy,
  input  logic [23:0]             dp_odata,
  output logic                    odata_vld,
  input  logic                    odata_rdy,
  output logic [23:0]             odata,
  output logic [$clog2(NCH)-1:0]  ochan
);

  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(BLK);
  localparam int PW   = $clog2(TAGD);

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   rr_last;
  logic [CNTW-1:0] cnt;

  logic [CW-1:0]   tag_mem [TAGD];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     occ;

  logic            arb_found;
  logic            arb_upd_rr;
  logic [CW-1:0]   arb_win;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            dp_xfer;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == (PW+1)'(TAGD));
  assign push       = (state == IDLE) && arb_found && !fifo_full;
  assign dp_xfer    = dp_idata_vld && dp_idata_rdy;
  assign pop        = odata_vld && odata_rdy;

  // Arbitration: first requester after rr_last, wrapping around.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    idx        = 0;
    arb_found  = 1'b0;
    arb_win    = '0;
    arb_upd_rr = 1'b1;
`ifdef AVGVAR_SCHED_PRIO0_EN
    if (ch_vld[0]) begin
      arb_found  = 1'b1;
      arb_upd_rr = 1'b0;
    end else begin
      for (int k = 1; k < NCH; k++) begin
        idx = ((int'(rr_last) - 1 + k) % (NCH - 1)) + 1;
        if (!arb_found && ch_vld[idx]) begin
          arb_found = 1'b1;
          arb_win   = CW'(idx);
        end
      end
    end
`else
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_last) + k) % NCH;
      if (!arb_found && ch_vld[idx]) begin
        arb_found = 1'b1;
        arb_win   = CW'(idx);
      end
    end
`endif
  end

  // Input path: route the granted channel to the datapath while in FEED.
  always_comb begin
    ch_rdy       = '0;
    dp_idata_vld = 1'b0;
    dp_idata     = '0;
    if (state == FEED) begin
      ch_rdy[grant] = dp_idata_rdy;
      dp_idata_vld  = ch_vld[grant];
      dp_idata      = ch_data[int'(grant)*8 +: 8];
    end
  end

  // Output path: results pass straight through, gated by tag availability.
  assign odata        = dp_odata;
  assign odata_vld    = dp_odata_vld && !fifo_empty;
  assign dp_odata_rdy = odata_rdy && !fifo_empty;
  assign ochan        = fifo_empty ? '0 : tag_mem[rd_ptr];

  // Block FSM: grant a channel in IDLE, count BLK transfers in FEED.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_last <= CW'(NCH - 1);
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            grant <= arb_win;
            if (arb_upd_rr) rr_last <= arb_win;
            cnt   <= '0;
            state <= FEED;
          end
        end
        FEED: begin
          if (dp_xfer) begin
            if (cnt == CNTW'(BLK - 1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Tag FIFO storage holds the granted channel of each outstanding block.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never visible
    // because ochan is forced to 0 whenever the FIFO is empty.
    if (push) tag_mem[wr_ptr] <= arb_win;
  end

endmodule

// File: tb/tb_avgvar_sched.sv
// Testbench for avgvar_sched: directed and random stimulus, a behavioural
// AvgVar datapath stand-in, and a per-channel reference of block results.
module tb_avgvar_sched;

  localparam int NCH  = 4;
  localparam int BLK  = 8;
  localparam int TAGD = 4;
  localparam int MAXS = 2048;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      ch_vld;
  logic [NCH-1:0]      ch_rdy;
  logic [8*NCH-1:0]    ch_data;
  logic                dp_idata_vld;
  logic                dp_idata_rdy;
  logic [7:0]          dp_idata;
  logic                dp_odata_vld;
  logic                dp_odata_rdy;
  logic [23:0]         dp_odata;
  logic                odata_vld;
  logic                odata_rdy;
  logic [23:0]         odata;
  logic [1:0]          ochan;

  avgvar_sched #(.NCH(NCH), .BLK(BLK), .TAGD(TAGD)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_vld       (ch_vld),
    .ch_rdy       (ch_rdy),
    .ch_data      (ch_data),
    .dp_idata_vld (dp_idata_vld),
    .dp_idata_rdy (dp_idata_rdy),
    .dp_idata     (dp_idata),
    .dp_odata_vld (dp_odata_vld),
    .dp_odata_rdy (dp_odata_rdy),
    .dp_odata     (dp_odata),
    .odata_vld    (odata_vld),
    .odata_rdy    (odata_rdy),
    .odata        (odata),
    .ochan        (ochan)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source, datapath and reference state.
  int           src_left [NCH];
  logic [7:0]   sent [NCH][MAXS];
  int           sent_n [NCH];
  int           rd_n [NCH];
  int           grant_hist [$];
  int           out_hist [$];
  logic [23:0]  odata_hist [$];
  int           out_cnt;
  int           blk_cnt;
  int           cur_blk_ch;
  logic [7:0]   dp_acc [$];
  logic [23:0]  dp_res [$];
  int           p_vld, p_drdy, p_ordy;
  bit           fixed_en;
  logic [7:0]   fixed_val;

  // Per-cycle snapshot taken at the falling edge.
  logic [NCH-1:0] snap_ch_rdy, snap_ch_vld;
  bit             snap_dp_x, snap_dpo_x, snap_o_x, snap_dp_odata_rdy;
  int             snap_ch_x;
  logic [7:0]     snap_dp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mean and population variance of one block, integer-truncated.
  function automatic logic [23:0] mean_var(input int sum, input int sq);
    int avg, vr;
    avg = sum / BLK;
    vr  = sq / BLK - avg * avg;
    return {avg[7:0], vr[15:0]};
  endfunction

  function automatic logic [23:0] ref_result(input int c, input int start);
    int sum, sq, v;
    sum = 0;
    sq  = 0;
    for (int i = 0; i < BLK; i++) begin
      v   = int'(sent[c][start + i]);
      sum += v;
      sq  += v * v;
    end
    return mean_var(sum, sq);
  endfunction

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      if (!ch_vld[c] && src_left[c] > 0 && $urandom_range(255) < p_vld) begin
        ch_vld[c] = 1'b1;
        ch_data[8*c +: 8] = fixed_en ? fixed_val : 8'($urandom_range(255));
      end
    end
    dp_idata_rdy = ($urandom_range(255) < p_drdy);
    odata_rdy    = ($urandom_range(255) < p_ordy);
    dp_odata_vld = (dp_res.size() > 0);
    dp_odata     = (dp_res.size() > 0) ? dp_res[0] : 24'h0;
  endtask

  task automatic cycle();
    int n;
    int sum, sq;
    @(negedge clk);
    snap_ch_rdy       = ch_rdy;
    snap_ch_vld       = ch_vld;
    snap_dp_x         = dp_idata_vld && dp_idata_rdy;
    snap_dpo_x        = dp_odata_vld && dp_odata_rdy;
    snap_o_x          = odata_vld && odata_rdy;
    snap_dp_odata_rdy = dp_odata_rdy;
    snap_dp_data      = dp_idata;
    snap_ch_x         = -1;
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_vld[c] && ch_rdy[c]) begin
        n++;
        snap_ch_x = c;
      end
    end
    if (snap_dp_x || n > 0) check("xfer_count", n, snap_dp_x);
    if (snap_dp_x && snap_ch_x >= 0) begin
      check("xfer_data", dp_idata, ch_data[8*snap_ch_x +: 8]);
      if (blk_cnt == 0) begin
        grant_hist.push_back(snap_ch_x);
        cur_blk_ch = snap_ch_x;
      end else begin
        check("blk_chan", snap_ch_x, cur_blk_ch);
      end
      blk_cnt = (blk_cnt + 1) % BLK;
      sent[snap_ch_x][sent_n[snap_ch_x]] = dp_idata;
      sent_n[snap_ch_x]++;
    end
    if (grant_hist.size() > out_cnt) begin
      check("odata_vld", odata_vld, dp_odata_vld);
      if (dp_odata_vld) check("dp_odata_rdy", dp_odata_rdy, odata_rdy);
    end else begin
      check("odata_vld_idle", odata_vld, 1'b0);
    end
    if (snap_o_x) begin
      if (grant_hist.size() > out_cnt) begin
        check("ochan", ochan, grant_hist[out_cnt]);
        check("odata", odata, ref_result(grant_hist[out_cnt], rd_n[grant_hist[out_cnt]]));
        rd_n[grant_hist[out_cnt]] += BLK;
      end
      out_hist.push_back(int'(ochan));
      odata_hist.push_back(odata);
      out_cnt++;
    end
    @(posedge clk);
    #1;
    if (snap_ch_x >= 0) begin
      ch_vld[snap_ch_x] = 1'b0;
      src_left[snap_ch_x]--;
    end
    if (snap_dpo_x && dp_res.size() > 0) void'(dp_res.pop_front());
    if (snap_dp_x) begin
      dp_acc.push_back(snap_dp_data);
      if (dp_acc.size() == BLK) begin
        sum = 0;
        sq  = 0;
        foreach (dp_acc[i]) begin
          sum += int'(dp_acc[i]);
          sq  += int'(dp_acc[i]) * int'(dp_acc[i]);
        end
        dp_res.push_back(mean_var(sum, sq));
        dp_acc.delete();
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    ch_vld       = '0;
    ch_data      = '0;
    dp_idata_rdy = 1'b0;
    odata_rdy    = 1'b0;
    dp_odata_vld = 1'b0;
    dp_odata     = '0;
    for (int c = 0; c < NCH; c++) begin
      src_left[c] = 0;
      sent_n[c]   = 0;
      rd_n[c]     = 0;
    end
    dp_acc.delete();
    dp_res.delete();
    grant_hist.delete();
    out_hist.delete();
    odata_hist.delete();
    out_cnt  = 0;
    blk_cnt  = 0;
    p_vld    = 256;
    p_drdy   = 256;
    p_ordy   = 256;
    fixed_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  task automatic run_outputs(input string tag, input int n, input int budget);
    int start, k;
    start = out_cnt;
    k = 0;
    while (out_cnt - start < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, out_cnt - start, n);
  endtask

  initial begin
    int exp_cont [6];
    int exp_prio [4];
    int cnt_seen;
    int k;

    // Reset state with every input pulled high.
    rst          = 1'b1;
    ch_vld       = '1;
    ch_data      = '1;
    dp_idata_rdy = 1'b1;
    odata_rdy    = 1'b1;
    dp_odata_vld = 1'b1;
    dp_odata     = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ch_rdy", ch_rdy, '0);
    check("rst_dp_idata_vld", dp_idata_vld, 1'b0);
    check("rst_dp_odata_rdy", dp_odata_rdy, 1'b0);
    check("rst_odata_vld", odata_vld, 1'b0);
    check("rst_ochan", ochan, 2'd0);

    // Stray result with no outstanding tag is held off.
    do_reset();
    dp_res.push_back(24'hABCDEF);
    drive();
    repeat (3) begin
      cycle();
      check("stray_dp_odata_rdy", snap_dp_odata_rdy, 1'b0);
    end

    // Single channel: ch1 sends eight samples of 10.
    do_reset();
    fixed_en     = 1'b1;
    fixed_val    = 8'd10;
    src_left[1]  = BLK;
    drive();
    cycle();
    check("bubble_vld", snap_ch_vld[1], 1'b1);
    check("bubble_rdy", snap_ch_rdy[1], 1'b0);
    cycle();
    check("feed_rdy", snap_ch_rdy[1], 1'b1);
    run_outputs("single_done", 1, 40);
    check("single_ochan", out_hist[0], 1);
    check("single_odata", odata_hist[0], {8'd10, 16'd0});

    // Contention among ch0, ch2, ch3.
    do_reset();
    src_left[0] = 6 * BLK;
    src_left[2] = 6 * BLK;
    src_left[3] = 6 * BLK;
    drive();
    run_outputs("cont_done", 6, 200);
    exp_cont = '{0, 2, 3, 0, 2, 3};
    for (int i = 0; i < 6; i++) check("cont_grant", grant_hist[i], exp_cont[i]);
    for (int i = 0; i < 6; i++) check("cont_ochan", out_hist[i], exp_cont[i]);

    // Mid-block stall: ch2 stops after three samples while ch0 waits.
    do_reset();
    src_left[2] = 3;
    drive();
    k = 0;
    while (sent_n[2] < 3 && k < 20) begin
      cycle();
      k++;
    end
    check("stall_first3", sent_n[2], 3);
    src_left[0] = BLK;
    drive();
    cnt_seen = 0;
    repeat (10) begin
      cycle();
      if (snap_ch_rdy[0]) cnt_seen++;
    end
    check("stall_rdy0", cnt_seen, 0);
    check("stall_samples2", sent_n[2], 3);
    check("stall_grants", grant_hist.size(), 1);
    src_left[2] = 5;
    drive();
    run_outputs("stall_done", 2, 80);
    check("stall_grant0", grant_hist[0], 2);
    check("stall_grant1", grant_hist[1], 0);

    // Backpressure: consumer stalled, four blocks fill the tag FIFO.
    do_reset();
    p_ordy = 0;
    for (int c = 0; c < NCH; c++) src_left[c] = 8 * BLK;
    drive();
    cnt_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (i >= 40 && snap_ch_rdy != '0) cnt_seen++;
    end
    check("bp_grants", grant_hist.size(), TAGD);
    check("bp_all_rdy_low", cnt_seen, 0);
    p_ordy = 256;
    drive();
    p_ordy = 0;
    cycle();
    check("bp_pop", snap_o_x, 1'b1);
    check("bp_rdy_pop_cycle", snap_ch_rdy, 4'b0000);
    cycle();
    check("bp_rdy_arb_cycle", snap_ch_rdy, 4'b0000);
    cycle();
    check("bp_new_grant", snap_ch_rdy, 4'b0001);

    // Random pacing on every handshake.
    do_reset();
    p_vld  = 128;
    p_drdy = 192;
    p_ordy = 192;
    for (int c = 0; c < NCH; c++) src_left[c] = 40 * BLK;
    drive();
    run_outputs("rand_done", 100, 20000);

    // ch0 and ch1 both continuously valid.
    do_reset();
    src_left[0] = 8 * BLK;
    src_left[1] = 8 * BLK;
    drive();
    run_outputs("prio_done", 4, 120);
`ifdef AVGVAR_SCHED_PRIO0_EN
    exp_prio = '{0, 0, 0, 0};
`else
    exp_prio = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) check("prio_grant", grant_hist[i], exp_prio[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avgvar_sched.md
Name: avgvar_sched

Overview:
Round-robin scheduler that shares one AvgVar datapath (8-bit sample in, 24-bit {avg[7:0],var[15:0]} out) between NCH independent sample streams. It locks the datapath input to one channel for a whole block of BLK samples, then re-arbitrates. It tags each AvgVar result with the channel that produced it, using an in-order tag FIFO. It sits between the per-channel sample sources and the shared AvgVar instance, and drives a single tagged result stream to the consumer.

Parameters:
NCH, 4, number of requesting channels (2..8)
BLK, 8, samples per AvgVar result block; must match the AvgVar instance
TAGD, 4, tag FIFO depth = max blocks outstanding inside AvgVar (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
ch_vld  in  NCH  per-channel sample valid
ch_rdy  out  NCH  per-channel sample ready
ch_data  in  8*NCH  per-channel sample; channel i occupies [8i+7:8i]
dp_idata_vld  out  1  sample valid to AvgVar
dp_idata_rdy  in  1  sample ready from AvgVar
dp_idata  out  8  sample to AvgVar
dp_odata_vld  in  1  result valid from AvgVar
dp_odata_rdy  out  1  result ready to AvgVar
dp_odata  in  24  result from AvgVar
odata_vld  out  1  tagged result valid
odata_rdy  in  1  consumer ready
odata  out  24  result, passed through unmodified
ochan  out  clog2(NCH)  channel index of the current odata

Behaviour:
- Handshakes: a transfer occurs when vld & rdy at a rising clk edge. A source holds vld and data stable until the transfer.
- Reset: state=IDLE, grant=0, rr_last=NCH-1 (channel 0 wins first), cnt=0, tag FIFO empty. All outputs 0: ch_rdy, dp_idata_vld, dp_odata_rdy, odata_vld, ochan.
- FSM IDLE: arbitrate among channels with ch_vld=1, searching from rr_last+1 upward and wrapping.
  - Arbitration requires tag FIFO occupancy < TAGD. A pop in the same cycle does not count.
  - On a winner w: grant<=w, rr_last<=w, cnt<=0, push w into the tag FIFO, go to FEED.
  - No request, or FIFO full: stay in IDLE.
  - ch_rdy=0 throughout IDLE, so one bubble cycle occurs per block.
- FSM FEED (combinational muxing):
  - dp_idata_vld = ch_vld[grant], dp_idata = ch_data[grant].
  - ch_rdy[grant] = dp_idata_rdy; all other ch_rdy = 0.
  - cnt increments on each datapath transfer.
  - The transfer with cnt==BLK-1 returns the FSM to IDLE with cnt<=0.
- No preemption: if ch_vld[grant] drops mid-block, the FSM waits in FEED indefinitely with grant held.
- Output path (combinational):
  - odata = dp_odata.
  - odata_vld = dp_odata_vld & ~fifo_empty.
  - dp_odata_rdy = odata_rdy & ~fifo_empty.
  - ochan = FIFO head (0 when empty).
  - The FIFO pops on odata_vld & odata_rdy.
- Simultaneous FIFO push (grant) and pop (result) in one cycle: both take effect and occupancy is unchanged.
- A result from AvgVar while the tag FIFO is empty is a protocol error: it is held off (dp_odata_rdy=0) and never forwarded.
- Reset asserted mid-block: the partial block is abandoned and all state returns to reset values. AvgVar shares rst, so it is flushed too.
- Zero added latency on the data paths. Arbitration latency is 1 cycle.

Optional Feature:
- Macro: AVGVAR_SCHED_PRIO0_EN.
- Defined: channel 0 has strict priority in IDLE. If ch_vld[0]=1 it wins regardless of rr_last and rr_last is left unchanged. Channels 1..NCH-1 round-robin among themselves when channel 0 is idle.
- Undefined: pure round-robin over all NCH channels, exactly as in Behaviour.

Test Plan:
- Single channel: ch1 sends 8 samples of 10, others idle, consumer always ready -> one output with odata={8'd10,16'd0}, ochan=1; ch_rdy[1]=0 during the IDLE cycle before the block.
- Contention: ch0, ch2 and ch3 all continuously valid -> block grant order 0,2,3,0,2,3. Each result's ochan matches the grant order, and no block mixes samples from two channels.
- Mid-block stall: ch2 drops ch_vld after 3 samples while ch0 is valid -> grant stays on 2 and ch_rdy[0] stays 0. When ch2 resumes, its remaining 5 samples complete the block; then ch0 is granted.
- Backpressure: odata_rdy=0 while 4 blocks are granted with TAGD=4 -> no 5th grant and all ch_rdy=0. One odata transfer frees a slot, and a new grant occurs the following cycle.
- Random pacing: random ch_vld, dp_idata_rdy and odata_rdy (192/256 ready) for 100 results -> the per-channel avg/var values match the reference model, and the ochan sequence equals the grant sequence.
- AVGVAR_SCHED_PRIO0_EN defined, ch0 and ch1 both continuously valid -> every block is granted to ch0. With the macro undefined, grants alternate 0,1,0,1.
